// File: rtl/cmp_stream_tracker.sv
// cmp_stream_tracker: consumes a frame of COUNT unsigned samples over a
// valid/ready handshake and tracks the frame maximum, minimum and the number
// of samples that tied the running maximum, plus the G/L/E flags of the most
// recent compare against the running maximum.
// Optional feature macro: TRACK_MIN_EN (when undefined, min_val is tied to 0).
module cmp_stream_tracker #(
   parameter int WIDTH = 4,
   parameter int COUNT = 8,
   localparam int CW   = $clog2(COUNT + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] min_val,
   output logic [CW-1:0]    eq_cnt,
   output logic             last_g,
   output logic             last_l,
   output logic             last_e,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          first;
   logic          last;
   logic          clear;

   assign accept = in_valid & in_ready;
   assign first  = (cnt == '0);
   assign last   = (cnt == CW'(COUNT - 1));
   assign clear  = (state == IDLE) & start;

   // State register; reset abandons any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and state-decoded handshake/status outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (accept && last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sample counter, running max, tie counter and compare flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         max_val <= '0;
         eq_cnt  <= '0;
         last_g  <= 1'b0;
         last_l  <= 1'b0;
         last_e  <= 1'b0;
      end else if (clear) begin
         cnt     <= '0;
         max_val <= '0;
         eq_cnt  <= '0;
         last_g  <= 1'b0;
         last_l  <= 1'b0;
         last_e  <= 1'b0;
      end else if (accept) begin
         cnt <= cnt + CW'(1);
         if (first) begin
            // First sample seeds the running max; no compare is reported.
            max_val <= in_data;
            last_g  <= 1'b0;
            last_l  <= 1'b0;
            last_e  <= 1'b0;
         end else begin
            last_g <= (in_data > max_val);
            last_l <= (in_data < max_val);
            last_e <= (in_data == max_val);
            if (in_data > max_val) max_val <= in_data;
            if (in_data == max_val) eq_cnt <= eq_cnt + CW'(1);
         end
      end
   end

`ifdef TRACK_MIN_EN
   logic [WIDTH-1:0] min_q;

   // Running minimum, seeded by the first sample of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= '0;
      end else if (clear) begin
         min_q <= '0;
      end else if (accept) begin
         if (first || (in_data < min_q)) min_q <= in_data;
      end
   end

   assign min_val = min_q;
`else
   assign min_val = '0;
`endif

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Self-checking bench for cmp_stream_tracker (COUNT=4). A reference model
// computes per-frame expectations that are queued when a frame is driven and
// popped when the block signals done.
module tb_cmp_stream_tracker;
   localparam int W  = 4;
   localparam int C  = 4;
   localparam int CW = $clog2(C + 1);

   typedef logic [W-1:0] frame_t [C];
   typedef struct {
      logic [W-1:0]  mx;
      logic [W-1:0]  mn;
      logic [CW-1:0] eq;
      logic          g, l, e;
      int            lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready;
   logic [W-1:0]  max_val;
   logic [W-1:0]  min_val;
   logic [CW-1:0] eq_cnt;
   logic          last_g, last_l, last_e, busy, done;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];

   cmp_stream_tracker #(.WIDTH(W), .COUNT(C)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .max_val(max_val),
      .min_val(min_val), .eq_cnt(eq_cnt), .last_g(last_g), .last_l(last_l),
      .last_e(last_e), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reference model: walk the frame and push the expected result.
   task automatic push_expect(input frame_t s, input int stall_len);
      exp_t x;
      x.mx = s[0]; x.mn = s[0]; x.eq = '0;
      x.g = 1'b0; x.l = 1'b0; x.e = 1'b0;
      for (int i = 1; i < C; i++) begin
         x.g = (s[i] > x.mx);
         x.l = (s[i] < x.mx);
         x.e = (s[i] == x.mx);
         if (x.e) x.eq = x.eq + 1'b1;
         if (x.g) x.mx = s[i];
         if (s[i] < x.mn) x.mn = s[i];
      end
`ifndef TRACK_MIN_EN
      x.mn = '0;
`endif
      x.lat = C + stall_len;
      sb.push_back(x);
   endtask

   // Drive one frame, wait for done, then compare against the queued result.
   task automatic run_frame(input string nm, input frame_t s, input int stall_at,
                            input int stall_len, input bit pulse_start,
                            input bit valid_after);
      exp_t x;
      int   st;
      int   n;
      push_expect(s, stall_len);
      start = 1'b1;
      step;
      start = 1'b0;
      st = cyc;
      total++;
      if ({in_ready, busy, done} !== 3'b110) begin
         bad++;
         $display("FAIL %s_run_entry got=%b want=110", nm, {in_ready, busy, done});
      end
      for (int i = 0; i < C; i++) begin
         if (i == stall_at) begin
            in_valid = 1'b0;
            repeat (stall_len) step;
         end
         in_valid = 1'b1;
         in_data  = s[i];
         if (pulse_start && i == 1) start = 1'b1;
         step;
         start = 1'b0;
      end
      if (valid_after) begin
         in_valid = 1'b1;
         in_data  = 4'hA;
      end else begin
         in_valid = 1'b0;
      end
      n = 0;
      while (done !== 1'b1 && n < 10) begin
         step;
         n++;
      end
      x = sb.pop_front();
      total++;
      if (n >= 10) begin
         bad++;
         $display("FAIL %s_done_timeout got=no_done want=done", nm);
      end
      total++;
      if (cyc - st !== x.lat) begin
         bad++;
         $display("FAIL %s_done_latency got=%0d want=%0d", nm, cyc - st, x.lat);
      end
      total++;
      if ({max_val, min_val, eq_cnt, last_g, last_l, last_e} !==
          {x.mx, x.mn, x.eq, x.g, x.l, x.e}) begin
         bad++;
         $display("FAIL %s_result got=max%0d min%0d eq%0d gle%b%b%b want=max%0d min%0d eq%0d gle%b%b%b",
                  nm, max_val, min_val, eq_cnt, last_g, last_l, last_e,
                  x.mx, x.mn, x.eq, x.g, x.l, x.e);
      end
      step;
      total++;
      if ({done, busy, in_ready} !== 3'b000) begin
         bad++;
         $display("FAIL %s_done_pulse got=%b want=000", nm, {done, busy, in_ready});
      end
      step;
      total++;
      if ({max_val, min_val, eq_cnt, last_g, last_l, last_e} !==
          {x.mx, x.mn, x.eq, x.g, x.l, x.e}) begin
         bad++;
         $display("FAIL %s_hold got=max%0d min%0d eq%0d want=max%0d min%0d eq%0d",
                  nm, max_val, min_val, eq_cnt, x.mx, x.mn, x.eq);
      end
      in_valid = 1'b0;
      $display("frame %s: max=%0d min=%0d eq=%0d gle=%b%b%b latency=%0d",
               nm, max_val, min_val, eq_cnt, last_g, last_l, last_e, cyc - st);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) step;
      total++;
      if ({in_ready, busy, done, max_val, min_val, eq_cnt, last_g, last_l, last_e} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0",
                  {in_ready, busy, done, max_val, min_val, eq_cnt, last_g, last_l, last_e});
      end
      #2 rst_n = 1'b1;
      step;
      $display("reset: outputs checked");
   endtask

   task automatic test_basic;
      frame_t f = '{4'd5, 4'd9, 4'd9, 4'd2};
      run_frame("basic", f, C, 0, 1'b0, 1'b0);
   endtask

   task automatic test_stalls;
      frame_t f = '{4'd5, 4'd9, 4'd9, 4'd2};
      run_frame("stall", f, 2, 3, 1'b0, 1'b0);
   endtask

   task automatic test_all_equal;
      frame_t f1 = '{4'hF, 4'hF, 4'hF, 4'hF};
      frame_t f0 = '{4'h0, 4'h0, 4'h0, 4'h0};
      frame_t fg = '{4'd2, 4'd7, 4'd1, 4'd12};
      run_frame("all_f", f1, C, 0, 1'b0, 1'b0);
      run_frame("all_0", f0, C, 0, 1'b0, 1'b0);
      run_frame("rise_end", fg, C, 0, 1'b0, 1'b0);
   endtask

   task automatic test_ignored;
      frame_t f = '{4'd5, 4'd9, 4'd9, 4'd2};
      frame_t h = '{4'd3, 4'd3, 4'd8, 4'd1};
      // Valid in IDLE must not be consumed nor disturb held results.
      in_valid = 1'b1;
      in_data  = 4'hA;
      repeat (3) begin
         step;
         total++;
         if ({in_ready, max_val} !== {1'b0, 4'd12}) begin
            bad++;
            $display("FAIL idle_valid got=rdy%b max%0d want=rdy0 max12", in_ready, max_val);
         end
      end
      in_valid = 1'b0;
      run_frame("start_in_run", f, C, 0, 1'b1, 1'b1);
      run_frame("after_ignored", h, C, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midframe;
      frame_t f = '{4'd6, 4'd1, 4'd6, 4'd4};
      start = 1'b1;
      step;
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 4'd7;
      step;
      in_data = 4'd3;
      step;
      in_valid = 1'b0;
      total++;
      if ({max_val, last_l} !== {4'd7, 1'b1}) begin
         bad++;
         $display("FAIL midframe_partial got=max%0d l%b want=max7 l1", max_val, last_l);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, busy, done, max_val, min_val, eq_cnt, last_g, last_l, last_e} !== '0) begin
         bad++;
         $display("FAIL midframe_reset got=%b want=0",
                  {in_ready, busy, done, max_val, min_val, eq_cnt, last_g, last_l, last_e});
      end
      step;
      #2 rst_n = 1'b1;
      step;
      total++;
      if ({in_ready, busy} !== 2'b00) begin
         bad++;
         $display("FAIL midframe_idle got=%b want=00", {in_ready, busy});
      end
      $display("reset mid-frame: outputs cleared");
      run_frame("post_reset", f, C, 0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stalls;
      test_all_equal;
      test_ignored;
      test_reset_midframe;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=hang want=finish");
      $fatal(1, "timeout");
   end
endmodule
